// File: rtl/game_sequencer_if.sv
// Level-memory and player-block handshake of the game sequencer.
// The sequencer is the master; level memory / player movement sit on the slave side.
interface game_sequencer_if;
  logic       load_req;
  logic [1:0] level;
  logic       load_done;
  logic       win;
  logic       move_up;
  logic       move_down;
  logic       move_left;
  logic       move_right;

  modport master (
    output load_req, level, move_up, move_down, move_left, move_right,
    input  load_done, win
  );

  modport slave (
    input  load_req, level, move_up, move_down, move_left, move_right,
    output load_done, win
  );
endinterface

// File: rtl/game_sequencer.sv
// Game flow controller: title -> load level -> play -> win hold -> next level / done.
// All outputs are registered from the next-state decode so they line up with the state.
module game_sequencer #(
  parameter int NUM_LEVELS = 3,
  parameter int MOVE_DIV   = 2,
  parameter int WIN_HOLD   = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic frame_tick,
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  output logic titleScreen,
  output logic allDone,
  game_sequencer_if.master bus
);

  typedef enum logic [2:0] {TITLE, LOAD, PLAY, WINHOLD, DONE} state_t;

  localparam logic [3:0] DIV_LAST   = 4'(MOVE_DIV - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(WIN_HOLD - 1);
  localparam logic [1:0] LEVEL_LAST = 2'(NUM_LEVELS - 1);

  state_t     state_q, state_d;
  logic       start_q;
  logic       start_edge;
  logic [3:0] div_q, div_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] level_q, level_d;
  logic [3:0] move_q, move_d;  // {up, down, left, right}
  logic       load_req_q;
  logic       title_q;
  logic       all_done_q;

  assign start_edge = start & ~start_q;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    hold_d  = '0;
    level_d = level_q;
    move_d  = '0;
    case (state_q)
      TITLE: begin
        if (start_edge) state_d = LOAD;
      end
      LOAD: begin
        if (bus.load_done) state_d = PLAY;
      end
      PLAY: begin
        div_d = div_q;
        if (bus.win) begin
          state_d = WINHOLD;
        end else if (frame_tick) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            // Opposing directions cancel each other out.
            move_d = {up & ~down, down & ~up, left & ~right, right & ~left};
          end else begin
            div_d = div_q + 4'd1;
          end
        end
      end
      WINHOLD: begin
        hold_d = hold_q;
        if (frame_tick) begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (level_q == LEVEL_LAST) begin
              state_d = DONE;
            end else begin
              level_d = level_q + 2'd1;
              state_d = LOAD;
            end
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      DONE: begin
        if (start_edge) begin
          state_d = TITLE;
          level_d = '0;
        end
      end
      default: state_d = TITLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TITLE;
      start_q    <= 1'b0;
      div_q      <= '0;
      hold_q     <= '0;
      level_q    <= '0;
      move_q     <= '0;
      load_req_q <= 1'b0;
      title_q    <= 1'b1;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      div_q      <= div_d;
      hold_q     <= hold_d;
      level_q    <= level_d;
      move_q     <= move_d;
      load_req_q <= (state_d == LOAD);
      title_q    <= (state_d == TITLE) || (state_d == DONE);
      all_done_q <= (state_d == DONE);
    end
  end

  assign titleScreen    = title_q;
  assign allDone        = all_done_q;
  assign bus.load_req   = load_req_q;
  assign bus.level      = level_q;
  assign bus.move_up    = move_q[3];
  assign bus.move_down  = move_q[2];
  assign bus.move_left  = move_q[1];
  assign bus.move_right = move_q[0];

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with NUM_LEVELS=3, MOVE_DIV=2, WIN_HOLD=4.
module tb_game_sequencer;

  logic clk = 1'b0;
  logic reset, start, frame_tick, up, down, left, right;
  logic titleScreen, allDone;
  int   checks = 0;
  int   errors = 0;
  int   strobes;

  game_sequencer_if bus ();

  game_sequencer #(.NUM_LEVELS(3), .MOVE_DIV(2), .WIN_HOLD(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_tick (frame_tick),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .titleScreen(titleScreen),
    .allDone    (allDone),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after an edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic check_moves(input string tag, input logic [3:0] exp);
    check(tag, {bus.move_up, bus.move_down, bus.move_left, bus.move_right}, {4'h0, exp});
  endtask

  // From LOAD: finish loading, win, hold 4 frames; expect next LOAD or DONE.
  task automatic finish_level(input logic [1:0] next_level, input logic last);
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    check("lvl_play_load_req", bus.load_req, 0);
    bus.win = 1'b1;
    tick();
    bus.win = 1'b0;
    repeat (3) frame();
    check("lvl_hold_no_exit", {bus.load_req, allDone}, 0);
    frame();
    if (last) begin
      check("lvl_done_all", allDone, 1);
      check("lvl_done_title", titleScreen, 1);
      check("lvl_done_level", bus.level, 2);
      check("lvl_done_load_req", bus.load_req, 0);
    end else begin
      check("lvl_next_load_req", bus.load_req, 1);
      check("lvl_next_level", bus.level, {6'h0, next_level});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    bus.load_done = 1'b0; bus.win = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_title", titleScreen, 1);
    check("rst_load_req", bus.load_req, 0);
    check("rst_level", bus.level, 0);
    check("rst_all_done", allDone, 0);
    check_moves("rst_moves", 4'b0000);

    // load_done in TITLE is ignored
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    check("title_ld_ignored", {titleScreen, bus.load_req}, 8'h2);

    // Start pulse, 5 cycles of no load_done, then load_done
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_entry_req", bus.load_req, 1);
    check("load_entry_title", titleScreen, 0);
    strobes = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.load_req) strobes++;
    end
    check("load_req_cycles", 8'(strobes), 6);
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    check("play_load_req", bus.load_req, 0);
    check("play_title", titleScreen, 0);

    // Right held over 6 frames -> strobe after every second frame
    right = 1'b1;
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      frame();
      check("right_step", bus.move_right, (i % 2 == 1) ? 1'b1 : 1'b0);
      if (bus.move_right) strobes++;
      tick();
      check("right_single", bus.move_right, 0);
    end
    check("right_count", 8'(strobes), 3);
    right = 1'b0;

    // up+down cancel, left passes
    up = 1'b1; down = 1'b1; left = 1'b1;
    frame();
    check_moves("udl_no_step", 4'b0000);
    frame();
    check_moves("udl_step", 4'b0010);
    up = 1'b0; down = 1'b0; right = 1'b1;
    frame(); frame();
    check_moves("lr_cancel", 4'b0000);
    left = 1'b0;

    // Win on a step tick: no strobe, WINHOLD, right held stays silent
    frame();
    check("pre_win_no_step", bus.move_right, 0);
    bus.win = 1'b1;
    frame();
    bus.win = 1'b0;
    check("win_step_no_strobe", bus.move_right, 0);
    for (int i = 0; i < 3; i++) begin
      frame();
      check_moves("hold_no_moves", 4'b0000);
    end
    check("hold_level0", {bus.load_req, bus.level}, 0);
    frame();
    right = 1'b0;
    check("hold_exit_load", bus.load_req, 1);
    check("hold_exit_level", bus.level, 1);

    // win in LOAD is ignored
    bus.win = 1'b1;
    tick();
    bus.win = 1'b0;
    check("load_win_ignored", {bus.load_req, bus.level}, 8'h5);

    // Reset in WINHOLD at level 1, with start held through release
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    bus.win = 1'b1;
    tick();
    bus.win = 1'b0;
    frame();
    reset = 1'b1; start = 1'b1;
    tick();
    check("rst_hold_title", titleScreen, 1);
    check("rst_hold_level", bus.level, 0);
    check("rst_hold_load_req", bus.load_req, 0);
    check("rst_hold_done", allDone, 0);
    check_moves("rst_hold_moves", 4'b0000);
    tick();
    reset = 1'b0;
    tick();
    check("rst_release_start", bus.load_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check("rst_mid_load", bus.load_req, 0);
    check("rst_mid_load_title", titleScreen, 1);

    // Full three-level game
    start = 1'b1;
    tick();
    start = 1'b0;
    check("game_l0_level", bus.level, 0);
    finish_level(2'd1, 1'b0);
    finish_level(2'd2, 1'b0);
    finish_level(2'd0, 1'b1);
    start = 1'b1;
    tick();
    check("done_exit_all", allDone, 0);
    check("done_exit_level", bus.level, 0);
    check("done_exit_title", titleScreen, 1);
    tick(); tick();
    check("held_start_no_retrig", bus.load_req, 0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("new_edge_load", bus.load_req, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter NUM_LEVELS, 3, number of levels played in order (legal range 1..4).
REQ-002 Parameter MOVE_DIV, 2, frame_tick pulses per player movement step (legal range 1..15).
REQ-003 Parameter WIN_HOLD, 60, frame_tick pulses the win state is held before advancing (legal range 1..255).
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  user start button, level signal.
REQ-007 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-008 up, down, left, right  input  1 each  raw direction requests from user.
REQ-009 win  input  1  player reached goal region (from player movement block).
REQ-010 load_done  input  1  level memory reports selected level loaded.
REQ-011 titleScreen  output  1  high while title is displayed; gates player movement.
REQ-012 load_req  output  1  request to load level selected by level.
REQ-013 level  output  2  index of current level, 0..NUM_LEVELS-1.
REQ-014 move_up, move_down, move_left, move_right  output  1 each  one-cycle movement strobes to player block.
REQ-015 allDone  output  1  all levels completed.

Function
REQ-016 FSM states SHALL be TITLE, LOAD, PLAY, WINHOLD, DONE; all outputs registered.
REQ-017 start SHALL be registered once (start_q); start edge = start & ~start_q; holding start SHALL NOT retrigger.
REQ-018 TITLE: titleScreen=1; start edge -> LOAD next cycle.
REQ-019 LOAD: load_req=1 from first LOAD cycle until exit; load_done=1 -> PLAY next cycle, load_req=0 in that same next cycle.
REQ-020 load_done outside LOAD SHALL be ignored.
REQ-021 titleScreen SHALL be 0 in LOAD, PLAY, WINHOLD; 1 in TITLE and DONE.
REQ-022 PLAY: divider counter (4 bits) SHALL increment on each frame_tick; on frame_tick with counter==MOVE_DIV-1 it wraps to 0 and a move step is issued.
REQ-023 Move step: each move_x SHALL be 1 for exactly the next cycle iff its direction input was 1 in the step cycle; up&down both 1 -> neither strobed; left&right both 1 -> neither strobed.
REQ-024 Divider SHALL be cleared to 0 on every entry to PLAY.
REQ-025 PLAY: win=1 -> WINHOLD next cycle; win takes priority, no move strobe issued for a step coinciding with win.
REQ-026 Move strobes SHALL be 0 in all states other than PLAY.
REQ-027 WINHOLD: hold counter (8 bits) cleared on entry, increments per frame_tick; on frame_tick with count==WIN_HOLD-1: if level==NUM_LEVELS-1 -> DONE, else level<=level+1 and -> LOAD.
REQ-028 win input SHALL be ignored in all states other than PLAY.
REQ-029 DONE: allDone=1; start edge -> TITLE with level<=0, allDone<=0.
REQ-030 level SHALL change only in WINHOLD exit and DONE exit; never exceeds NUM_LEVELS-1.

Reset
REQ-031 reset=1 at a clock edge SHALL, regardless of state, set state=TITLE, level=0, titleScreen=1, load_req=0, all move strobes=0, allDone=0, divider=0, hold counter=0, start_q=0.
REQ-032 reset SHALL take priority over every other input in the same cycle, including mid-LOAD (load_req drops next edge).
REQ-033 A start held high through reset release SHALL produce one start edge on the first cycle after release (start_q=0).

Verification
REQ-034 Reset, pulse start, hold load_done low 5 cycles then high -> load_req high exactly 6 cycles, titleScreen 0 from LOAD entry, state PLAY next cycle.
REQ-035 PLAY, MOVE_DIV=2, right held, 6 frame_ticks -> exactly 3 single-cycle move_right strobes, one after each even tick.
REQ-036 PLAY, up and down both held with left, step -> move_left only; move_up/move_down stay 0.
REQ-037 NUM_LEVELS=3, WIN_HOLD=4: win in each level plus 4 frame_ticks -> level sequence 0,1,2, then allDone=1 and titleScreen=1; start edge -> TITLE, level=0.
REQ-038 win coincident with step tick -> no strobe, WINHOLD next cycle; win pulsed in LOAD -> ignored.
REQ-039 reset asserted in WINHOLD at level 1 -> next cycle TITLE, level 0, all outputs at reset values.
